// File: rtl/mnisc_stream_pkg.sv
// Shared stream-unit definitions: state enum, config struct and config legality checks,
// used by both the pooling and upsampling units.
package mnisc_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_FILL,
    ST_EMIT,
    ST_DONE
  } stream_state_e;

  localparam logic [7:0] ELEM_2  = 8'd2;
  localparam logic [7:0] ELEM_4  = 8'd4;
  localparam logic [7:0] ELEM_8  = 8'd8;
  localparam logic [7:0] ELEM_16 = 8'd16;
  localparam logic [7:0] ELEM_32 = 8'd32;

  typedef struct packed {
    logic [7:0]  elem_bits;
    logic [15:0] h_in;
    logic [15:0] w_in;
    logic [15:0] c;
  } stream_cfg_t;

  function automatic logic elem_legal(input logic [7:0] e);
    return (e == ELEM_2) || (e == ELEM_4) || (e == ELEM_8) ||
           (e == ELEM_16) || (e == ELEM_32);
  endfunction

  function automatic logic [31:0] pixel_bits(input stream_cfg_t cfg);
    return 32'(cfg.c) * 32'(cfg.elem_bits);
  endfunction

  function automatic logic [31:0] pixel_beats(input stream_cfg_t cfg, input int unsigned bus_w);
    return pixel_bits(cfg) / bus_w;
  endfunction

  function automatic logic [47:0] row_beats(input stream_cfg_t cfg, input int unsigned bus_w);
    return 48'(cfg.w_in) * 48'(pixel_beats(cfg, bus_w));
  endfunction

  // A pixel must occupy a whole number of beats and a full row must fit the line buffer.
  function automatic logic cfg_valid(input stream_cfg_t cfg, input int unsigned bus_w,
                                     input int unsigned max_row_beats);
    return elem_legal(cfg.elem_bits) &&
           ((pixel_bits(cfg) % bus_w) == 32'd0) &&
           (cfg.h_in != 16'd0) && (cfg.w_in != 16'd0) && (cfg.c != 16'd0) &&
           (row_beats(cfg, bus_w) <= 48'(max_row_beats));
  endfunction

endpackage

// File: rtl/upsample2d_unit_if.sv
// Valid/ready beat stream; master drives data/valid, slave drives ready.
interface upsample2d_unit_if #(parameter int W = 128) ();
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/upsample_line_buf.sv
// Single-row buffer: flop array with one write port and one combinational read port.
module upsample_line_buf #(
  parameter int DEPTH = 256,
  parameter int W     = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/upsample2d_unit.sv
// 2x nearest-neighbour upsampler: buffers one input row, then replays it as two output rows
// with every pixel emitted twice.
module upsample2d_unit
  import mnisc_stream_pkg::*;
#(
  parameter int BUS_W         = 128,
  parameter int MAX_ROW_BEATS = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         cfg_elem_bits,
  input  logic [15:0]        cfg_h_in,
  input  logic [15:0]        cfg_w_in,
  input  logic [15:0]        cfg_c,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  upsample2d_unit_if.slave   act_in,
  upsample2d_unit_if.master  out
);

  localparam int AW = $clog2(MAX_ROW_BEATS);

  stream_state_e    state_q, state_d;
  stream_cfg_t      cfg_q;
  logic             err_q;
  logic             cfg_ok;
  logic [AW-1:0]    pb_m1_q, rb_m1_q, wr_ptr_q, rd_idx_q, b_q;
  logic [16:0]      ow_q, w2_m1_q;
  logic             rep_q;
  logic [15:0]      row_cnt_q;
  logic [BUS_W-1:0] rd_data;
  logic             in_fire, out_fire, b_last, ow_last, last_row, row_done;

  assign cfg_ok   = cfg_valid(cfg_q, BUS_W, MAX_ROW_BEATS);
  assign in_fire  = (state_q == ST_FILL) && act_in.valid;
  assign out_fire = (state_q == ST_EMIT) && out.ready;
  assign b_last   = (b_q == pb_m1_q);
  assign ow_last  = (ow_q == w2_m1_q);
  assign row_done = rep_q && ow_last && b_last;
  assign last_row = ((row_cnt_q + 16'd1) == cfg_q.h_in);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_CHECK;
      ST_CHECK: state_d = cfg_ok ? ST_FILL : ST_DONE;
      ST_FILL:  if (in_fire && (wr_ptr_q == rb_m1_q)) state_d = ST_EMIT;
      ST_EMIT:  if (out_fire && row_done) state_d = last_row ? ST_DONE : ST_FILL;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q     <= '0;
      err_q     <= 1'b0;
      pb_m1_q   <= '0;
      rb_m1_q   <= '0;
      w2_m1_q   <= '0;
      wr_ptr_q  <= '0;
      rd_idx_q  <= '0;
      b_q       <= '0;
      ow_q      <= '0;
      rep_q     <= 1'b0;
      row_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) cfg_q <= '{cfg_elem_bits, cfg_h_in, cfg_w_in, cfg_c};
        ST_CHECK: begin
          err_q     <= !cfg_ok;
          pb_m1_q   <= AW'(pixel_beats(cfg_q, BUS_W) - 32'd1);
          rb_m1_q   <= AW'(row_beats(cfg_q, BUS_W) - 48'd1);
          w2_m1_q   <= {cfg_q.w_in, 1'b0} - 17'd1;
          wr_ptr_q  <= '0;
          rd_idx_q  <= '0;
          b_q       <= '0;
          ow_q      <= '0;
          rep_q     <= 1'b0;
          row_cnt_q <= '0;
        end
        ST_FILL: if (in_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
        ST_EMIT: if (out_fire) begin
          if (!b_last) begin
            b_q      <= b_q + 1'b1;
            rd_idx_q <= rd_idx_q + 1'b1;
          end else begin
            b_q <= '0;
            if (ow_last) begin
              ow_q     <= '0;
              rd_idx_q <= '0;
              rep_q    <= ~rep_q;
              if (rep_q) begin
                row_cnt_q <= row_cnt_q + 16'd1;
                wr_ptr_q  <= '0;
              end
            end else begin
              ow_q     <= ow_q + 17'd1;
              // Even ow: replay the same pixel; odd ow: step on to the next one.
              rd_idx_q <= ow_q[0] ? rd_idx_q + 1'b1 : rd_idx_q - pb_m1_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  upsample_line_buf #(.DEPTH(MAX_ROW_BEATS), .W(BUS_W), .AW(AW)) u_line_buf (
    .clk   (clk),
    .we    (in_fire),
    .waddr (wr_ptr_q),
    .wdata (act_in.data),
    .raddr (rd_idx_q),
    .rdata (rd_data)
  );

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign err          = (state_q == ST_DONE) && err_q;
  assign act_in.ready = (state_q == ST_FILL);
  assign out.valid    = (state_q == ST_EMIT);
  assign out.data     = (state_q == ST_EMIT) ? rd_data : '0;

endmodule
